uart_slip_deframer: RTL
=======================

// Module: uart_slip_deframer
// PURPOSE
//   Consumes the byte stream from the UART receiver (valid/ready, one byte per
//   transfer). Decodes SLIP framing (END/ESC escapes) into a byte stream with
//   last/error sideband for the packet/command layer. One byte of lookahead marks
//   m_last on the final payload byte of each frame. Empty frames are discarded.
// PARAMETERS
//   MAX_LEN  256  maximum decoded payload bytes per frame; excess bytes are dropped
//                 and the frame is flagged as an error
// PORTS
//   clk      in   1  clock
//   reset    in   1  synchronous, active-high reset
//   s_valid  in   1  input byte valid (from UART receiver)
//   s_ready  out  1  input byte accepted when s_valid && s_ready
//   s_data   in   8  raw SLIP-encoded byte
//   m_valid  out  1  output byte valid
//   m_ready  in   1  downstream accept
//   m_data   out  8  decoded payload byte
//   m_last   out  1  final byte of frame (qualified by m_valid)
//   m_error  out  1  frame had a bad escape or overflowed (valid only with m_last)
// BEHAVIOUR
//   - Reset: m_valid=0, m_data=0, m_last=0, m_error=0, hold empty, state NORMAL,
//     len=0, err flag=0. Reset mid-frame discards the partial frame and pending output.
//   - s_ready = !m_valid || m_ready (combinational). A byte is consumed on accept.
//   - Output is a registered stage: m_* change only when !m_valid || m_ready.
//     m_valid clears on m_valid && m_ready unless a new byte is loaded the same cycle.
//   - Constants: END=8'hC0, ESC=8'hDB, ESC_END=8'hDC, ESC_ESC=8'hDD.
//   - FSM, advanced only on accept:
//     NORMAL: END -> end-of-frame; ESC -> ESCAPE; other -> decoded byte = s_data.
//     ESCAPE: DC -> decoded C0, go NORMAL; DD -> decoded DB, go NORMAL;
//             END -> set err, end-of-frame, go NORMAL;
//             other -> set err, drop byte, go NORMAL.
//   - Decoded byte: if len == MAX_LEN, set err and drop the byte. Otherwise len++.
//     If hold is full, emit hold (last=0) and write the new byte to hold.
//     If hold is empty, only load hold.
//   - End-of-frame:
//     hold full -> emit hold with last=1, error=err.
//     hold empty and err=1 -> emit data=8'h00, last=1, error=1 (error marker).
//     hold empty and err=0 -> emit nothing (empty frame dropped).
//     In every case: clear hold, len and err.
//   - Latency: output appears the cycle after the accepting edge. An END accepted
//     at cycle t gives m_valid && m_last at t+1.
//   - At most one output per accepted input, so the single output register is enough.
//   - len width is $clog2(MAX_LEN+1) bits; it saturates at MAX_LEN and never wraps.
//   - Bytes before the first END are treated as a frame. There is no sync hunt:
//     a leading END just closes an empty frame.
// STRUCTURE
//   - uart_pkg holds the SLIP constants (SLIP_END, SLIP_ESC, SLIP_ESC_END,
//     SLIP_ESC_ESC) and typedef enum logic {NORMAL, ESCAPE} slip_state_t.
//   - Single module, no sub-modules. Hold register, output register and FSM are
//     separate always_ff blocks.
// TESTING
//   1. 01 02 03 C0, m_ready=1 -> 01,02,03; last=1 only on 03; error=0.
//   2. DB DC DB DD C0 -> C0, DB(last=1, error=0).
//   3. C0 C0 C0 -> no m_valid asserted.
//   4. 05 DB 41 06 C0 -> 05, 06(last=1, error=1).
//      Then DB 41 C0 -> single 00(last=1, error=1).
//   5. MAX_LEN=4: 11 22 33 44 55 66 C0 -> 11,22,33, 44(last=1, error=1).
//      Next frame 77 C0 -> 77(last=1, error=0).
//   6. Hold m_ready=0 for 10 cycles mid-frame -> s_ready=0, m_data/m_last stable.
//      Then pulse reset, send 07 C0 -> only 07(last=1); no pre-reset byte emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// SLIP framing constants and decoder state type shared by the UART byte path.
package uart_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic {
        NORMAL,
        ESCAPE
    } slip_state_t;

endpackage

// File: rtl/uart_slip_deframer.sv
// SLIP deframer: decodes END/ESC framing from the UART receiver into a payload
// stream with last/error sideband, using one held byte as lookahead for m_last.
module uart_slip_deframer
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       m_error
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    slip_state_t state, state_next;

    logic             accept;
    logic             dec_valid;
    logic [7:0]       dec_byte;
    logic             frame_end;
    logic             bad_escape;

    logic [7:0]       hold_data;
    logic             hold_full;
    logic [LEN_W-1:0] len;
    logic             err;

    logic             overflow;
    logic             store;
    logic             emit;
    logic [7:0]       emit_data;
    logic             emit_last;
    logic             emit_error;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NORMAL;
        end else if (accept) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dec_valid  = 1'b0;
        dec_byte   = s_data;
        frame_end  = 1'b0;
        bad_escape = 1'b0;
        case (state)
            NORMAL: begin
                if (s_data == SLIP_END) begin
                    frame_end = 1'b1;
                end else if (s_data == SLIP_ESC) begin
                    state_next = ESCAPE;
                end else begin
                    dec_valid = 1'b1;
                end
            end
            ESCAPE: begin
                state_next = NORMAL;
                if (s_data == SLIP_ESC_END) begin
                    dec_valid = 1'b1;
                    dec_byte  = SLIP_END;
                end else if (s_data == SLIP_ESC_ESC) begin
                    dec_valid = 1'b1;
                    dec_byte  = SLIP_ESC;
                end else begin
                    // An END after ESC still closes the frame, but flagged as bad.
                    bad_escape = 1'b1;
                    frame_end  = (s_data == SLIP_END);
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    always_comb begin
        overflow   = accept && dec_valid && (len == LEN_MAX);
        store      = accept && dec_valid && !overflow;
        emit       = 1'b0;
        emit_data  = hold_data;
        emit_last  = 1'b0;
        emit_error = 1'b0;
        if (store && hold_full) begin
            emit = 1'b1;
        end else if (accept && frame_end) begin
            if (hold_full) begin
                emit       = 1'b1;
                emit_last  = 1'b1;
                emit_error = err || bad_escape;
            end else if (err || bad_escape) begin
                // Nothing left to tag, so report the bad frame with a zero marker byte.
                emit       = 1'b1;
                emit_data  = '0;
                emit_last  = 1'b1;
                emit_error = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            len       <= '0;
            err       <= 1'b0;
        end else if (accept && frame_end) begin
            hold_full <= 1'b0;
            len       <= '0;
            err       <= 1'b0;
        end else begin
            if (store) begin
                hold_data <= dec_byte;
                hold_full <= 1'b1;
                len       <= len + 1'b1;
            end
            if (overflow || (accept && bad_escape)) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_error <= 1'b0;
        end else if (s_ready) begin
            m_valid <= emit;
            if (emit) begin
                m_data  <= emit_data;
                m_last  <= emit_last;
                m_error <= emit_error;
            end
        end
    end

endmodule
